// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad matrix scanner: FSM state
// encodings, key-code constants and the (row, column) -> key-code map.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Physical layout: r0=1 2 3 A, r1=4 5 6 B, r2=7 8 9 C, r3=* 0 # D
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = 4'd10;
            4'd4:    code = 4'd4;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd6;
            4'd7:    code = 4'd11;
            4'd8:    code = 4'd7;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd9;
            4'd11:   code = 4'd12;
            4'd12:   code = KEY_STAR;
            4'd13:   code = 4'd0;
            4'd14:   code = KEY_HASH;
            4'd15:   code = 4'd13;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    // Digits 1..8 light bit (n-1) of the game bus; every other key leaves it dark
    function automatic logic [7:0] digit_onehot(input logic [3:0] code);
        logic [7:0] bus;
        if ((code >= 4'd1) && (code <= 4'd8)) begin
            bus = 8'd1 << (code - 4'd1);
        end else begin
            bus = 8'd0;
        end
        return bus;
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Board-pin and game-side signals of the keypad scanner.
// master: the scanner itself; slave: the board/game side.
interface keypad_matrix_scanner_if;
    logic [3:0] row_in;     // active-low rows, asynchronous to clk
    logic [3:0] col_drv;    // active-low column drive, one bit low
    logic [7:0] keypad;     // one-hot digit level while held
    logic [3:0] key_code;   // last accepted key
    logic       key_valid;  // one-cycle accept strobe
    logic       key_held;   // key currently held

    modport master (
        input  row_in,
        output col_drv, keypad, key_code, key_valid, key_held
    );

    modport slave (
        output row_in,
        input  col_drv, keypad, key_code, key_valid, key_held
    );
endinterface

// File: rtl/keypad_tick_gen.sv
// Free-running prescaler: emits a one-cycle scan tick every SCAN_DIV clocks.
module keypad_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,       // asynchronous, active-low
    output logic tick_o
);
    localparam int           DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_q;

    // Prescaler counts 0..SCAN_DIV-1 and wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign tick_o = (div_q == DIV_LAST);
endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 membrane keypad scanner: rotates an active-low column strobe, samples
// synchronized rows once per scan tick, debounces one key at a time and
// reports it as key code, accept strobe, held level and one-hot digit bus.
// Optional auto-repeat of key_valid while held: define KEYPAD_REPEAT_EN.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 64,
    parameter int REPEAT_RATE    = 16
) (
    input  logic clk,
    input  logic rst,       // asynchronous, active-low
    keypad_matrix_scanner_if.master kif
);
    localparam int MAX_A   = (DEBOUNCE_SCANS > REPEAT_DELAY) ? DEBOUNCE_SCANS : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
    logic [CNT_W-1:0] rep_q, rep_d;
`endif

    kp_state_e        state_q, state_d;
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       row_q, row_d;
    logic [3:0]       code_q, code_d;
    logic [7:0]       keypad_q, keypad_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;

    logic       tick_s;
    logic [3:0] rows_low_s;
    logic       one_low_s, all_high_s;
    logic [1:0] row_idx_s, col_idx_s, acc_row_s;
    logic [3:0] col_rot_s;
    logic       accept_s;

    keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick_s)
    );

    // Two-flop synchronizer for the asynchronous row inputs (idle = all high)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
        end else begin
            sync1_q <= kif.row_in;
            sync2_q <= sync1_q;
        end
    end

    assign rows_low_s = ~sync2_q;
    assign all_high_s = (sync2_q == 4'b1111);
    // Exactly one row low; two or more is a ghost and is rejected
    assign one_low_s  = (rows_low_s != 4'd0) && ((rows_low_s & (rows_low_s - 4'd1)) == 4'd0);
    assign col_rot_s  = {col_q[2:0], col_q[3]};

    // Row and driven-column indices from their one-hot/one-cold patterns
    always_comb begin
        case (rows_low_s)
            4'b0010: row_idx_s = 2'd1;
            4'b0100: row_idx_s = 2'd2;
            4'b1000: row_idx_s = 2'd3;
            default: row_idx_s = 2'd0;
        endcase
        case (col_q)
            4'b1101: col_idx_s = 2'd1;
            4'b1011: col_idx_s = 2'd2;
            4'b0111: col_idx_s = 2'd3;
            default: col_idx_s = 2'd0;
        endcase
    end

    // Scan/debounce/hold/release decisions, taken only on a scan tick
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        code_d    = code_q;
        keypad_d  = keypad_q;
        valid_d   = 1'b0;
        held_d    = held_q;
        accept_s  = 1'b0;
        acc_row_s = row_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d     = rep_q;
`endif
        if (tick_s) begin
            case (state_q)
                ST_SCAN: begin
                    if (one_low_s) begin
                        row_d     = row_idx_s;
                        acc_row_s = row_idx_s;
                        if (DEBOUNCE_SCANS <= 1) begin
                            accept_s = 1'b1;
                        end else begin
                            cnt_d   = CNT_ONE;
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        col_d = col_rot_s;
                    end
                end
                ST_DEBOUNCE: begin
                    if (one_low_s && (row_idx_s == row_q)) begin
                        if (cnt_q >= DEB_LAST) begin
                            accept_s = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (all_high_s) begin
                        if (cnt_q >= DEB_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_RELEASE;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        cnt_d = '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    // Repeat count restarts whenever the key looks released
                    if (all_high_s) begin
                        rep_d = '0;
                    end else if (rep_q >= REP_LAST) begin
                        valid_d = 1'b1;
                        rep_d   = REP_RELOAD;
                    end else begin
                        rep_d = rep_q + CNT_ONE;
                    end
`endif
                end
                ST_RELEASE: begin
                    keypad_d = 8'd0;
                    held_d   = 1'b0;
                    col_d    = col_rot_s;
                    cnt_d    = '0;
                    state_d  = ST_SCAN;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end
            endcase
            if (accept_s) begin
                code_d   = key_map(acc_row_s, col_idx_s);
                keypad_d = digit_onehot(key_map(acc_row_s, col_idx_s));
                valid_d  = 1'b1;
                held_d   = 1'b1;
                cnt_d    = '0;
                state_d  = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                rep_d    = '0;
`endif
            end else begin
                held_d = held_d;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // State and output registers; reset clears everything immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_SCAN;
            col_q    <= 4'b1110;
            cnt_q    <= '0;
            row_q    <= 2'd0;
            code_q   <= 4'd0;
            keypad_q <= 8'd0;
            valid_q  <= 1'b0;
            held_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            code_q   <= code_d;
            keypad_q <= keypad_d;
            valid_q  <= valid_d;
            held_q   <= held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q    <= rep_d;
`endif
        end
    end

    assign kif.col_drv   = col_q;
    assign kif.keypad    = keypad_q;
    assign kif.key_code  = code_q;
    assign kif.key_valid = valid_q;
    assign kif.key_held  = held_q;
endmodule
